// File: rtl/mux_select_sequencer.sv
// mux_select_sequencer
//
// Serialises 4-bit words through an external 4:1 bit multiplexer. A word is
// accepted on a valid/ready handshake, parked on the mux data bus (mux_a),
// and the mux select (mux_s) is stepped through all four lanes, each lane
// held for BIT_HOLD cycles. On the last cycle of each lane the mux output is
// captured into a registered serial stream with valid/last flags.
//
// Build option: define MSB_FIRST_EN to walk the lanes 3,2,1,0 instead of the
// default 0,1,2,3. Handshake and timing are identical in both builds.
//
// Handshake: a word transfers on any rising edge where in_valid & in_ready
// are both high. in_ready is combinational from state/counters only (never
// from in_valid), and in_valid while in_ready is low is simply ignored.
// The serial side has no backpressure: every serial_valid pulse must be
// taken by the consumer in the cycle it is presented.
//
// BIT_HOLD legal range is 1..16.

module mux_select_sequencer #(
    parameter int BIT_HOLD = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] mux_a,
    output logic [1:0] mux_s,
    input  logic       mux_o,
    output logic       serial_out,
    output logic       serial_valid,
    output logic       serial_last,
    output logic       busy,
    output logic [0:0] state_dbg
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    // Hold counter is at least one bit wide; with BIT_HOLD == 1 it is tied
    // to zero so every SHIFT cycle completes a lane.
    localparam int HOLD_W = (BIT_HOLD > 1) ? $clog2(BIT_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(BIT_HOLD - 1);

`ifdef MSB_FIRST_EN
    localparam logic [1:0] FIRST_LANE = 2'b11;
    localparam logic [1:0] FINAL_LANE = 2'b00;
`else
    localparam logic [1:0] FIRST_LANE = 2'b00;
    localparam logic [1:0] FINAL_LANE = 2'b11;
`endif

    // ------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------
    logic [0:0]        state;
    logic [HOLD_W-1:0] hold;
    logic [1:0]        lane_next;
    logic              shifting;
    logic              bit_done;
    logic              word_done;
    logic              accept;

    // mux_s doubles as the lane counter: in SHIFT it always shows the lane
    // currently being presented, and in IDLE it keeps the last lane used.

    // Lane step direction depends on the configured bit order.
    always_comb begin
        lane_next = mux_s;
`ifdef MSB_FIRST_EN
        lane_next = mux_s - 2'd1;
`else
        lane_next = mux_s + 2'd1;
`endif
    end

    // Per-cycle decode of where we are in the current word.
    always_comb begin
        shifting  = (state == SHIFT);
        bit_done  = shifting && (hold == HOLD_MAX);
        word_done = bit_done && (mux_s == FINAL_LANE);
        // Ready in IDLE, or in the very last cycle of a word so the next
        // word follows with no bubble.
        in_ready  = (state == IDLE) || word_done;
        accept    = in_valid && in_ready;
    end

    // FSM: IDLE -> SHIFT on accept; SHIFT -> IDLE when the final lane
    // completes without a follow-on word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (accept) begin
            state <= SHIFT;
        end else if (word_done) begin
            state <= IDLE;
        end
    end

    // Hold counter: counts cycles spent on the current lane.
    generate
        if (BIT_HOLD == 1) begin : g_hold_const
            assign hold = '0;
        end else begin : g_hold_cnt
            always_ff @(posedge clk) begin
                if (rst) begin
                    hold <= '0;
                end else if (accept || bit_done) begin
                    hold <= '0;
                end else if (shifting) begin
                    hold <= hold + HOLD_W'(1);
                end
            end
        end
    endgenerate

    // Mux drive: load the word and first lane on accept, then advance the
    // select each time a lane completes. Both hold their value in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            mux_a <= 4'b0000;
            mux_s <= 2'b00;
        end else if (accept) begin
            mux_a <= in_data;
            mux_s <= FIRST_LANE;
        end else if (bit_done && !word_done) begin
            mux_s <= lane_next;
        end
    end

    // Serial output: capture the settled mux output at the end of each lane
    // and flag it for exactly one cycle; last marks the final lane's bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            serial_last  <= 1'b0;
        end else begin
            serial_valid <= bit_done;
            serial_last  <= word_done;
            if (bit_done) begin
                serial_out <= mux_o;
            end
        end
    end

    // Status outputs.
    always_comb begin
        busy      = shifting;
        state_dbg = state;
    end

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Directed bench for mux_select_sequencer. Two instances run side by side:
// u_dut1 with BIT_HOLD = 1 and u_dut3 with BIT_HOLD = 3. Each has a bench
// model of the external 4:1 mux. Lane order expectations follow the
// MSB_FIRST_EN build option.

module tb_mux_select_sequencer;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // ------------------------------------------------------------------
    // DUT signals
    // ------------------------------------------------------------------
    logic [3:0] in_data1, in_data3;
    logic       in_valid1, in_valid3;
    logic       in_ready1, in_ready3;
    logic [3:0] mux_a1, mux_a3;
    logic [1:0] mux_s1, mux_s3;
    logic       mux_o1, mux_o3;
    logic       serial_out1, serial_out3;
    logic       serial_valid1, serial_valid3;
    logic       serial_last1, serial_last3;
    logic       busy1, busy3;
    logic [0:0] state1, state3;

    // External multiplexers.
    assign mux_o1 = mux_a1[mux_s1];
    assign mux_o3 = mux_a3[mux_s3];

    mux_select_sequencer #(.BIT_HOLD(1)) u_dut1 (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data1),
        .in_valid     (in_valid1),
        .in_ready     (in_ready1),
        .mux_a        (mux_a1),
        .mux_s        (mux_s1),
        .mux_o        (mux_o1),
        .serial_out   (serial_out1),
        .serial_valid (serial_valid1),
        .serial_last  (serial_last1),
        .busy         (busy1),
        .state_dbg    (state1)
    );

    mux_select_sequencer #(.BIT_HOLD(3)) u_dut3 (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data3),
        .in_valid     (in_valid3),
        .in_ready     (in_ready3),
        .mux_a        (mux_a3),
        .mux_s        (mux_s3),
        .mux_o        (mux_o3),
        .serial_out   (serial_out3),
        .serial_valid (serial_valid3),
        .serial_last  (serial_last3),
        .busy         (busy3),
        .state_dbg    (state3)
    );

    // ------------------------------------------------------------------
    // Check bookkeeping
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sampling and driving happen 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Lane presented for the k-th bit of a word.
    function automatic logic [1:0] lane_at(input int k);
`ifdef MSB_FIRST_EN
        return 2'(3 - k);
`else
        return 2'(k);
`endif
    endfunction

    task automatic chk_reset_values1(input string tag);
        chk({tag, "_ready1"}, in_ready1, 1'b1);
        chk({tag, "_mux_a1"}, mux_a1, 4'b0000);
        chk({tag, "_mux_s1"}, mux_s1, 2'b00);
        chk({tag, "_sout1"},  serial_out1, 1'b0);
        chk({tag, "_sval1"},  serial_valid1, 1'b0);
        chk({tag, "_slast1"}, serial_last1, 1'b0);
        chk({tag, "_busy1"},  busy1, 1'b0);
        chk({tag, "_state1"}, state1, 1'b0);
    endtask

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [3:0] w;
        logic [3:0] w2;
        rst       = 1'b1;
        in_data1  = 4'h0;
        in_valid1 = 1'b0;
        in_data3  = 4'h0;
        in_valid3 = 1'b0;
        tick();
        tick();

        // Reset values, both instances.
        chk_reset_values1("rst");
        chk("rst_ready3", in_ready3, 1'b1);
        chk("rst_mux_a3", mux_a3, 4'b0000);
        chk("rst_mux_s3", mux_s3, 2'b00);
        chk("rst_sval3",  serial_valid3, 1'b0);
        chk("rst_busy3",  busy3, 1'b0);
        rst = 1'b0;
        tick();

        // ---- Single word 1011, BIT_HOLD = 1 ----
        w = 4'b1011;
        in_data1  = w;
        in_valid1 = 1'b1;
        tick();                 // accept edge E0
        in_valid1 = 1'b0;
        chk("t1_busy", busy1, 1'b1);
        chk("t1_mux_a", mux_a1, w);
        chk("t1_sval0", serial_valid1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk("t1_mux_s", mux_s1, lane_at(k));
            tick();
            chk("t1_sval", serial_valid1, 1'b1);
            chk("t1_sout", serial_out1, w[lane_at(k)]);
            chk("t1_slast", serial_last1, (k == 3));
        end
        chk("t1_busy_end", busy1, 1'b0);
        chk("t1_ready_end", in_ready1, 1'b1);
        tick();
        chk("t1_sval_after", serial_valid1, 1'b0);
        chk("t1_slast_after", serial_last1, 1'b0);

        // ---- Single word 0110, BIT_HOLD = 3 ----
        w = 4'b0110;
        in_data3  = w;
        in_valid3 = 1'b1;
        tick();                 // accept edge E0
        in_valid3 = 1'b0;
        chk("t2_busy", busy3, 1'b1);
        for (int c = 0; c < 12; c++) begin
            chk("t2_mux_s", mux_s3, lane_at(c / 3));
            chk("t2_ready", in_ready3, (c == 11));
            tick();
            chk("t2_sval", serial_valid3, ((c + 1) % 3 == 0));
            chk("t2_slast", serial_last3, (c + 1 == 12));
            if ((c + 1) % 3 == 0)
                chk("t2_sout", serial_out3, w[lane_at((c + 1) / 3 - 1)]);
        end
        chk("t2_busy_end", busy3, 1'b0);
        chk("t2_mux_s_idle", mux_s3, lane_at(3));
        tick();
        chk("t2_sval_after", serial_valid3, 1'b0);

        // ---- Back-to-back A then 5, BIT_HOLD = 1 ----
        w  = 4'hA;
        w2 = 4'h5;
        in_data1  = w;
        in_valid1 = 1'b1;
        tick();                 // accept A
        in_data1 = w2;
        for (int n = 0; n < 8; n++) begin
            if (n == 4) in_valid1 = 1'b0;  // 5 was taken on the previous edge
            chk("t3_ready", in_ready1, (n % 4 == 3));
            chk("t3_busy", busy1, 1'b1);
            tick();
            chk("t3_sval", serial_valid1, 1'b1);
            chk("t3_sout", serial_out1, (n < 4) ? w[lane_at(n)] : w2[lane_at(n - 4)]);
            chk("t3_slast", serial_last1, (n % 4 == 3));
        end
        chk("t3_busy_end", busy1, 1'b0);
        tick();
        chk("t3_sval_after", serial_valid1, 1'b0);

        // ---- Reset after 2nd bit of word F, BIT_HOLD = 1 ----
        in_data1  = 4'hF;
        in_valid1 = 1'b1;
        tick();                 // accept
        in_valid1 = 1'b0;
        tick();                 // bit 1 out
        tick();                 // bit 2 out
        chk("t4_sval_pre", serial_valid1, 1'b1);
        chk("t4_busy_pre", busy1, 1'b1);
        rst = 1'b1;
        in_valid1 = 1'b1;       // handshake during reset must lose
        tick();
        chk_reset_values1("t4");
        rst = 1'b0;
        in_valid1 = 1'b0;
        for (int n = 0; n < 4; n++) begin
            tick();
            chk("t4_sval_quiet", serial_valid1, 1'b0);
            chk("t4_busy_quiet", busy1, 1'b0);
        end

        // ---- in_valid pulsed mid-word, BIT_HOLD = 3 ----
        w = 4'b1001;
        in_data3  = w;
        in_valid3 = 1'b1;
        tick();                 // accept
        in_valid3 = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (c == 4) begin
                in_data3  = 4'h3;
                in_valid3 = 1'b1;
                chk("t5_ready_mid", in_ready3, 1'b0);
            end else begin
                in_valid3 = 1'b0;
            end
            chk("t5_mux_a", mux_a3, w);
            tick();
            chk("t5_sval", serial_valid3, ((c + 1) % 3 == 0));
            if ((c + 1) % 3 == 0)
                chk("t5_sout", serial_out3, w[lane_at((c + 1) / 3 - 1)]);
        end
        in_valid3 = 1'b0;
        chk("t5_busy_end", busy3, 1'b0);
        for (int n = 0; n < 4; n++) begin
            tick();
            chk("t5_sval_quiet", serial_valid3, 1'b0);
        end

        // ---- Word 1000, BIT_HOLD = 1 (MSB-first build: 1,0,0,0) ----
        w = 4'b1000;
        in_data1  = w;
        in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("t6_mux_s", mux_s1, lane_at(k));
            tick();
            chk("t6_sval", serial_valid1, 1'b1);
            chk("t6_sout", serial_out1, w[lane_at(k)]);
            chk("t6_slast", serial_last1, (k == 3));
        end
        tick();
        chk("t6_sval_after", serial_valid1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
